// File: rtl/pacman_motion_ctrl_if.sv
// Wall-lookup query channel between the motion controller (master) and the maze-wall table (slave).
interface pacman_motion_ctrl_if;
    logic       wall_req;
    logic [9:0] wall_qx;
    logic [9:0] wall_qy;
    logic       wall_ack;
    logic       wall_hit;

    modport master (output wall_req, wall_qx, wall_qy, input wall_ack, wall_hit);
    modport slave  (input wall_req, wall_qx, wall_qy, output wall_ack, wall_hit);
endinterface

// File: rtl/pacman_motion_ctrl.sv
// PacMan sprite motion sequencer: latches direction requests, steps every STEP_DIV frames and
// checks each proposed move against the shared maze-wall lookup before committing it.
module pacman_motion_ctrl #(
    parameter int START_X  = 190,
    parameter int START_Y  = 150,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 629,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 469,
    parameter int STEP     = 1,
    parameter int STEP_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    input  logic                 key_valid,
    input  logic [1:0]           key_dir,
    pacman_motion_ctrl_if.master wall,
    output logic [9:0]           pac_x,
    output logic [9:0]           pac_y,
    output logic [1:0]           pac_dir,
    output logic                 mouth_open,
    output logic                 moving,
    output logic                 busy,
    output logic                 overrun
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);

    typedef enum logic [1:0] {IDLE, Q_NEW, Q_CUR, MOVE} state_t;

    state_t        state;
    logic [CW-1:0] frame_cnt;
    logic          pending_valid;
    logic [1:0]    pending_dir;
    logic [1:0]    q_dir;
    logic [20:0]   nxt_new;
    logic [20:0]   nxt_cur;
    logic          eff_valid;
    logic [1:0]    eff_dir;

    // Returns {blocked, next_x, next_y}; X wraps through the tunnel, Y stops at the maze edge.
    function automatic logic [20:0] next_pos(input logic [1:0] d, input logic [9:0] x,
                                             input logic [9:0] y);
        logic [10:0] sx;
        logic [10:0] sy;
        logic        blk;
        logic [9:0]  nx;
        logic [9:0]  ny;
        sx  = {1'b0, x} + 11'(STEP);
        sy  = {1'b0, y} + 11'(STEP);
        blk = 1'b0;
        nx  = x;
        ny  = y;
        case (d)
            2'b00: nx = (sx > 11'(X_MAX)) ? 10'(X_MIN) : sx[9:0];
            2'b01: if (y < 10'(Y_MIN + STEP)) blk = 1'b1; else ny = y - 10'(STEP);
            2'b10: nx = (x < 10'(X_MIN + STEP)) ? 10'(X_MAX) : x - 10'(STEP);
            default: if (sy > 11'(Y_MAX)) blk = 1'b1; else ny = sy[9:0];
        endcase
        return {blk, nx, ny};
    endfunction

    assign nxt_new   = next_pos(pending_dir, pac_x, pac_y);
    assign nxt_cur   = next_pos(pac_dir, pac_x, pac_y);
    assign eff_valid = key_valid | pending_valid;
    assign eff_dir   = key_valid ? key_dir : pending_dir;
    assign busy      = (state != IDLE);

    // A query state with wall_req low has not issued yet; it issues (or resolves a Y block) that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            frame_cnt     <= '0;
            pending_valid <= 1'b0;
            pending_dir   <= 2'b00;
            q_dir         <= 2'b00;
            pac_x         <= 10'(START_X);
            pac_y         <= 10'(START_Y);
            pac_dir       <= 2'b10;
            mouth_open    <= 1'b1;
            moving        <= 1'b0;
            overrun       <= 1'b0;
            wall.wall_req <= 1'b0;
            wall.wall_qx  <= '0;
            wall.wall_qy  <= '0;
        end else begin
            if (key_valid) begin
                pending_dir   <= key_dir;
                pending_valid <= 1'b1;
            end
            if (frame_tick && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        if (frame_cnt == CNT_LAST) begin
                            frame_cnt <= '0;
                            if (eff_valid && eff_dir != pac_dir) begin
                                state <= Q_NEW;
                            end else begin
                                if (eff_valid) pending_valid <= 1'b0;
                                state <= Q_CUR;
                                if (!nxt_cur[20]) begin
                                    wall.wall_req <= 1'b1;
                                    wall.wall_qx  <= nxt_cur[19:10];
                                    wall.wall_qy  <= nxt_cur[9:0];
                                end
                            end
                        end else begin
                            frame_cnt <= frame_cnt + CW'(1);
                        end
                    end
                end
                Q_NEW: begin
                    if (!wall.wall_req) begin
                        if (nxt_new[20]) begin
                            state <= Q_CUR;
                        end else begin
                            wall.wall_req <= 1'b1;
                            wall.wall_qx  <= nxt_new[19:10];
                            wall.wall_qy  <= nxt_new[9:0];
                            q_dir         <= pending_dir;
                        end
                    end else if (wall.wall_ack) begin
                        wall.wall_req <= 1'b0;
                        if (!wall.wall_hit) begin
                            pac_dir <= q_dir;
                            if (!key_valid) pending_valid <= 1'b0;
                            state <= MOVE;
                        end else begin
                            state <= Q_CUR;
                        end
                    end
                end
                Q_CUR: begin
                    if (!wall.wall_req) begin
                        if (nxt_cur[20]) begin
                            moving <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            wall.wall_req <= 1'b1;
                            wall.wall_qx  <= nxt_cur[19:10];
                            wall.wall_qy  <= nxt_cur[9:0];
                        end
                    end else if (wall.wall_ack) begin
                        wall.wall_req <= 1'b0;
                        if (wall.wall_hit) begin
                            moving <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state <= MOVE;
                        end
                    end
                end
                MOVE: begin
                    pac_x      <= wall.wall_qx;
                    pac_y      <= wall.wall_qy;
                    mouth_open <= ~mouth_open;
                    moving     <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// Scoreboard bench for pacman_motion_ctrl: directed moves, turns, tunnel wrap, edge block,
// slow wall lookup with overrun, and reset during a query.
module tb_pacman_motion_ctrl;

    typedef struct {
        int x;
        int y;
    } query_t;

    typedef struct {
        int x;
        int y;
        int dir;
        int mouth;
        int mv;
    } result_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       key_valid = 1'b0;
    logic [1:0] key_dir = 2'b00;
    logic [9:0] pac_x;
    logic [9:0] pac_y;
    logic [1:0] pac_dir;
    logic       mouth_open;
    logic       moving;
    logic       busy;
    logic       overrun;

    int errors = 0;
    int checks = 0;
    int ack_delay = 0;
    logic block_down = 1'b0;
    int exp_dir = 2;
    int exp_mouth = 1;

    query_t  q_exp[$];
    result_t r_exp[$];

    pacman_motion_ctrl_if wif ();

    pacman_motion_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .key_valid  (key_valid),
        .key_dir    (key_dir),
        .wall       (wif.master),
        .pac_x      (pac_x),
        .pac_y      (pac_y),
        .pac_dir    (pac_dir),
        .mouth_open (mouth_open),
        .moving     (moving),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] dir);
        @(negedge clk);
        key_valid = 1'b1;
        key_dir   = dir;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic pulseTick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic frameTick();
        pulseTick();
        repeat (10) @(negedge clk);
    endtask

    task automatic pushQuery(input int x, input int y);
        query_t q;
        q.x = x;
        q.y = y;
        q_exp.push_back(q);
    endtask

    task automatic pushResult(input int x, input int y, input int dir, input int mouth, input int mv);
        result_t r;
        r.x = x;
        r.y = y;
        r.dir = dir;
        r.mouth = mouth;
        r.mv = mv;
        r_exp.push_back(r);
    endtask

    // Non-step tick first, then the expectation, then the step tick, so an early step is caught.
    task automatic stepTo(input int qx, input int qy, input int pre_qx = -1, input int pre_qy = -1);
        frameTick();
        if (pre_qx >= 0) pushQuery(pre_qx, pre_qy);
        pushQuery(qx, qy);
        exp_mouth = 1 - exp_mouth;
        pushResult(qx, qy, exp_dir, exp_mouth, 1);
        frameTick();
    endtask

    // Wall lookup model: only a downward move is ever blocked, and only while block_down is set.
    initial begin
        wif.wall_ack = 1'b0;
        wif.wall_hit = 1'b0;
        forever begin
            @(negedge clk);
            if (wif.wall_req) begin
                repeat (ack_delay) @(negedge clk);
                if (wif.wall_req) begin
                    wif.wall_ack = 1'b1;
                    wif.wall_hit = block_down && (wif.wall_qy > pac_y);
                    @(negedge clk);
                    wif.wall_ack = 1'b0;
                    wif.wall_hit = 1'b0;
                end
            end
        end
    end

    // Monitor: a rising wall_req presents a query, a falling busy presents a finished evaluation.
    initial begin
        logic prev_req;
        logic prev_busy;
        prev_req  = 1'b0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req  = 1'b0;
                prev_busy = 1'b0;
            end else begin
                if (wif.wall_req && !prev_req) begin
                    if (q_exp.size() == 0) begin
                        checkOutput("unexpected_query_qx", int'(wif.wall_qx), -1);
                    end else begin
                        query_t q;
                        q = q_exp.pop_front();
                        checkOutput("query_qx", int'(wif.wall_qx), q.x);
                        checkOutput("query_qy", int'(wif.wall_qy), q.y);
                    end
                end
                if (prev_busy && !busy) begin
                    if (r_exp.size() == 0) begin
                        checkOutput("unexpected_step_pac_x", int'(pac_x), -1);
                    end else begin
                        result_t r;
                        r = r_exp.pop_front();
                        checkOutput("pac_x", int'(pac_x), r.x);
                        checkOutput("pac_y", int'(pac_y), r.y);
                        checkOutput("pac_dir", int'(pac_dir), r.dir);
                        checkOutput("mouth_open", int'(mouth_open), r.mouth);
                        checkOutput("moving", int'(moving), r.mv);
                    end
                end
                prev_req  = wif.wall_req;
                prev_busy = busy;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst_pac_x", int'(pac_x), 190);
        checkOutput("rst_pac_y", int'(pac_y), 150);
        checkOutput("rst_pac_dir", int'(pac_dir), 2);
        checkOutput("rst_mouth", int'(mouth_open), 1);
        checkOutput("rst_moving", int'(moving), 0);
        checkOutput("rst_overrun", int'(overrun), 0);
        checkOutput("rst_wall_req", int'(wif.wall_req), 0);
        checkOutput("rst_wall_qx", int'(wif.wall_qx), 0);
        checkOutput("rst_wall_qy", int'(wif.wall_qy), 0);
        checkOutput("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Straight left every second frame.
        stepTo(189, 150);
        stepTo(188, 150);

        // Turn up, continue up, turn left.
        applyStimulus(2'b01);
        exp_dir = 1;
        stepTo(188, 149);
        stepTo(188, 148);
        applyStimulus(2'b10);
        exp_dir = 2;
        stepTo(187, 148);

        // Down blocked: keeps going left, pending kept, turns once the wall is gone.
        block_down = 1'b1;
        applyStimulus(2'b11);
        stepTo(186, 148, 187, 149);
        block_down = 1'b0;
        exp_dir = 3;
        stepTo(186, 149);

        // Run left to the tunnel edge, wrap to X_MAX, then wrap back going right.
        applyStimulus(2'b10);
        exp_dir = 2;
        for (int x = 185; x >= 0; x--) stepTo(x, 149);
        stepTo(629, 149);
        applyStimulus(2'b00);
        exp_dir = 0;
        stepTo(0, 149);

        // Run up to the top edge; the next step is blocked with no query.
        applyStimulus(2'b01);
        exp_dir = 1;
        for (int y = 148; y >= 0; y--) stepTo(0, y);
        frameTick();
        pushResult(0, 0, 1, exp_mouth, 0);
        frameTick();
        checkOutput("top_block_pac_y", int'(pac_y), 0);

        // Slow wall lookup with a frame tick landing during the wait.
        ack_delay = 50;
        applyStimulus(2'b11);
        exp_dir = 3;
        frameTick();
        pushQuery(0, 1);
        exp_mouth = 1 - exp_mouth;
        pushResult(0, 1, 3, exp_mouth, 1);
        pulseTick();
        repeat (5) @(negedge clk);
        checkOutput("slow_req_held", int'(wif.wall_req), 1);
        pulseTick();
        repeat (3) @(negedge clk);
        checkOutput("slow_overrun", int'(overrun), 1);
        checkOutput("slow_req_still_held", int'(wif.wall_req), 1);
        checkOutput("slow_qx_stable", int'(wif.wall_qx), 0);
        checkOutput("slow_qy_stable", int'(wif.wall_qy), 1);
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        checkOutput("slow_ack_busy_done", int'(busy), 0);
        ack_delay = 0;
        stepTo(0, 2);

        // Reset in the middle of a direction-change query.
        ack_delay = 50;
        applyStimulus(2'b10);
        frameTick();
        pushQuery(629, 2);
        pulseTick();
        repeat (5) @(negedge clk);
        checkOutput("midq_req_before_reset", int'(wif.wall_req), 1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midq_rst_wall_req", int'(wif.wall_req), 0);
        checkOutput("midq_rst_pac_x", int'(pac_x), 190);
        checkOutput("midq_rst_pac_y", int'(pac_y), 150);
        checkOutput("midq_rst_overrun", int'(overrun), 0);
        checkOutput("midq_rst_pac_dir", int'(pac_dir), 2);
        checkOutput("midq_rst_busy", int'(busy), 0);
        repeat (60) @(negedge clk);
        ack_delay = 0;
        rst_n = 1'b1;
        exp_dir = 2;
        exp_mouth = 1;
        stepTo(189, 150);

        checkOutput("queries_drained", q_exp.size(), 0);
        checkOutput("results_drained", r_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pacman_motion_ctrl.md
Name: pacman_motion_ctrl

Overview:
- Sequences the PacMan sprite position consumed by the sprite display block: latches joystick/keyboard direction requests, steps the sprite once every STEP_DIV frames and arbitrates moves against a shared maze-wall lookup through a req/ack handshake.
- Outputs the sprite's top-left corner, facing direction and mouth-animation phase.
- The sprite renderer draws the 10x10 sprite using these outputs.

Parameters:
- START_X, 190, sprite left coordinate after reset
- START_Y, 150, sprite top coordinate after reset
- X_MIN, 0, leftmost legal left coordinate (tunnel edge)
- X_MAX, 629, rightmost legal left coordinate (tunnel edge)
- Y_MIN, 0, topmost legal top coordinate
- Y_MAX, 469, bottommost legal top coordinate
- STEP, 1, pixels moved per step
- STEP_DIV, 2, frames per step (>=1)

Ports:
- clk  in  1  system clock; all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per video frame (start of vertical blank)
- key_valid  in  1  one-cycle pulse: new direction request
- key_dir  in  2  requested direction: 00 right, 01 up, 10 left, 11 down
- wall_req  out  1  wall query request; held high until ack
- wall_qx  out  10  proposed sprite left coordinate under query
- wall_qy  out  10  proposed sprite top coordinate under query
- wall_ack  in  1  one-cycle query completion
- wall_hit  in  1  valid with wall_ack: 1 = proposed position blocked
- pac_x  out  10  sprite left coordinate
- pac_y  out  10  sprite top coordinate
- pac_dir  out  2  facing direction, same encoding as key_dir
- mouth_open  out  1  animation phase, toggles every completed step
- moving  out  1  1 = last evaluation produced a move
- busy  out  1  state != IDLE
- overrun  out  1  sticky: frame_tick arrived while busy

Behaviour:
- Reset values: pac_x=START_X, pac_y=START_Y, pac_dir=10, mouth_open=1, moving=0, overrun=0, wall_req=0, wall_qx=wall_qy=0, pending_valid=0, frame_cnt=0, state=IDLE. Reset aborts any query; wall_req drops immediately.
- Pending register: key_valid loads pending_dir and sets pending_valid in any state; the latest request wins. key_valid in the same cycle as frame_tick is visible to that frame's evaluation.
- Frame count: in IDLE on frame_tick, frame_cnt increments modulo STEP_DIV. A step starts only when frame_cnt==STEP_DIV-1 at the tick. frame_tick while busy is dropped and sets overrun; frame_cnt is not advanced.
- Next-position function for a given direction, 10-bit unsigned:
  - right: x+STEP; if >X_MAX, wrap to X_MIN.
  - left: if x<X_MIN+STEP, wrap to X_MAX; else x-STEP.
  - up: y-STEP; if y<Y_MIN+STEP, the move is blocked without a query.
  - down: y+STEP; if >Y_MAX, the move is blocked without a query.
- FSM states IDLE, Q_NEW, Q_CUR, MOVE:
  - IDLE: on a step-start tick, go to Q_NEW if pending_valid && pending_dir!=pac_dir; otherwise go to Q_CUR. If pending_valid && pending_dir==pac_dir, clear pending_valid.
  - Q_NEW: drive wall_qx/qy = next(pending_dir) and wall_req=1. These are registered on state entry and stable until ack. On ack && !hit: pac_dir<=pending_dir, clear pending_valid, go to MOVE with target latched. On ack && hit: go to Q_CUR; pending is kept for future steps. A Y-bound block skips the query and goes to Q_CUR.
  - Q_CUR: query next(pac_dir). On ack && !hit, go to MOVE. On ack && hit, or a Y-bound block: moving<=0, go to IDLE.
  - MOVE: one cycle; pac_x/pac_y<=latched target, mouth_open toggles, moving<=1, go to IDLE.
- wall_req deasserts in the cycle after wall_ack. wall_ack with wall_req low is ignored. Query wait has no timeout.
- Latency with a same-cycle ack: frame_tick to position update is 3 cycles via Q_CUR; a direction change adds 1 more.

Test Plan:
- Reset, STEP_DIV=2, ack always !hit, 4 frame_ticks -> pac_x 190->189->188 (on ticks 2 and 4), pac_dir=10, mouth_open toggles 1->0->1.
- key_dir=01 pulsed, next step-start tick, no wall -> wall_qx=190, wall_qy=149 queried, pac_dir=01, pac_y=149, pending_valid cleared.
- key_dir=11 with wall_hit=1 for down query and 0 for left query -> pac_dir stays 10, x decrements, pending kept; on the next step with down open -> turns down.
- pac_x=X_MIN=0 moving left -> query wall_qx=629; pac_x=629 after step. pac_y=0 moving up -> no wall_req, moving=0, position unchanged.
- wall_ack delayed 50 cycles and frame_tick pulsed during the wait -> wall_req held, qx/qy stable, overrun=1, frame_cnt unchanged.
- rst_n low mid-Q_NEW -> wall_req=0 asynchronously, pac_x=190, pac_y=150, overrun=0; normal operation resumes after release.
